// File: rtl/riscv_pkg.sv
// Shared RV64 front-end constants: NOP encoding, default XLEN, PC step and the PC source select.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 64;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          PC_INCREMENT = 4;

    typedef enum logic [1:0] {
        PC_SEL_ADVANCE  = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Priority: reset > bubble > hold > load.
module if_id_register
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            bubble,
    input  logic            load,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instruction,
    output logic            id_valid
);

    logic [XLEN-1:0] id_pc_r;
    logic [31:0]     id_instr_r;
    logic            id_valid_r;

    // Pipeline register update; a bubble always carries a NOP so decode needs no special case.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            id_pc_r    <= {XLEN{1'b0}};
            id_instr_r <= NOP_INSTR;
            id_valid_r <= 1'b0;
        end else if (hold) begin
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
            id_valid_r <= id_valid_r;
        end else if (load) begin
            id_pc_r    <= pc_in;
            id_instr_r <= instr_in;
            id_valid_r <= 1'b1;
        end else begin
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
            id_valid_r <= id_valid_r;
        end
    end

    assign id_pc          = id_pc_r;
    assign id_instruction = id_instr_r;
    assign id_valid       = id_valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux and IF/ID register.
// Optional macro FETCH_MISALIGN_CHECK_EN word-aligns redirects and raises a sticky misalign_err.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
)(
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] inst_address,
    input  logic [31:0]     instruction,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instruction,
    output logic            id_valid,
    output logic            misalign_err
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] redirect_pc_s;
    pc_sel_e         pc_sel_s;

    // Wraps modulo 2^XLEN by construction; no overflow flag.
    assign pc_plus4_s = pc_r + XLEN'(PC_INCREMENT);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_err_r;
    logic misalign_hit_s;

    assign redirect_pc_s  = {branch_target[XLEN-1:2], 2'b00};
    assign misalign_hit_s = branch_taken && (branch_target[1:0] != 2'b00);

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
        end else if (misalign_hit_s) begin
            misalign_err_r <= 1'b1;
        end else begin
            misalign_err_r <= misalign_err_r;
        end
    end

    assign misalign_err = misalign_err_r;
`else
    assign redirect_pc_s = branch_target;
    assign misalign_err  = 1'b0;
`endif

    // PC source selection: a redirect beats a stall.
    always_comb begin
        pc_sel_s = PC_SEL_ADVANCE;
        if (branch_taken) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (stall) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_ADVANCE;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEL_ADVANCE:  pc_next_s = pc_plus4_s;
            PC_SEL_HOLD:     pc_next_s = pc_r;
            PC_SEL_REDIRECT: pc_next_s = redirect_pc_s;
            default:         pc_next_s = pc_r;
        endcase
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign inst_address = pc_r;

    if_id_register #(
        .XLEN (XLEN)
    ) u_if_id (
        .clk            (clk),
        .reset          (reset),
        .hold           (stall),
        .bubble         (branch_taken),
        .load           (~stall),
        .pc_in          (pc_r),
        .instr_in       (instruction),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (RESET_PC 0 and near-wrap) share stimulus.
module tb_fetch_stage;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [63:0] RPC_A = 64'h0;
    localparam logic [63:0] RPC_B = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;

    logic [63:0] addr_a, id_pc_a, addr_b, id_pc_b;
    logic [31:0] instr_a, id_instr_a, instr_b, id_instr_b;
    logic        valid_a, merr_a, valid_b, merr_b;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] p;
        p = a * 64'd2654435761;
        return p[31:0] ^ a[63:32];
    endfunction

    assign instr_a = mem_word(addr_a);
    assign instr_b = mem_word(addr_b);

    fetch_stage #(.XLEN(64), .RESET_PC(RPC_A)) dut_a (
        .clk(clk), .reset(reset), .inst_address(addr_a), .instruction(instr_a),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_pc(id_pc_a), .id_instruction(id_instr_a), .id_valid(valid_a), .misalign_err(merr_a)
    );

    fetch_stage #(.XLEN(64), .RESET_PC(RPC_B)) dut_b (
        .clk(clk), .reset(reset), .inst_address(addr_b), .instruction(instr_b),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .id_pc(id_pc_b), .id_instruction(id_instr_b), .id_valid(valid_b), .misalign_err(merr_b)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] id_pc;
        logic [31:0] instr;
        logic        valid;
        logic        merr;
    } mstate_t;

    typedef struct {
        mstate_t a;
        mstate_t b;
    } exp_t;

    mstate_t ma, mb;
    exp_t    sb_q[$];
    exp_t    mon_e;
    int      n_pass = 0;
    int      n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Reference behaviour of one fetch stage for one clock edge.
    function automatic mstate_t step(input mstate_t s, input logic rst, input logic br,
                                     input logic [63:0] tgt, input logic st, input logic [63:0] rpc);
        mstate_t n = s;
        if (rst) begin
            n.pc = rpc; n.id_pc = 64'h0; n.instr = NOP; n.valid = 1'b0; n.merr = 1'b0;
        end else if (br) begin
            n.id_pc = 64'h0; n.instr = NOP; n.valid = 1'b0;
            if (CHK && (tgt % 64'd4 != 64'd0)) begin
                n.pc   = tgt - (tgt % 64'd4);
                n.merr = 1'b1;
            end else begin
                n.pc = tgt;
            end
        end else if (!st) begin
            n.id_pc = s.pc; n.instr = mem_word(s.pc); n.valid = 1'b1;
            n.pc    = s.pc + 64'd4;
        end
        return n;
    endfunction

    task automatic issue(input logic rst, input logic br, input logic [63:0] tgt, input logic st);
        exp_t e;
        @(negedge clk);
        reset = rst; branch_taken = br; branch_target = tgt; stall = st;
        ma = step(ma, rst, br, tgt, st, RPC_A);
        mb = step(mb, rst, br, tgt, st, RPC_B);
        e.a = ma; e.b = mb;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops one expected state per edge and compares both instances.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("a.inst_address", addr_a, mon_e.a.pc);
                check("a.id_pc", id_pc_a, mon_e.a.id_pc);
                check("a.id_instruction", 64'(id_instr_a), 64'(mon_e.a.instr));
                check("a.id_valid", 64'(valid_a), 64'(mon_e.a.valid));
                check("a.misalign_err", 64'(merr_a), 64'(mon_e.a.merr));
                check("b.inst_address", addr_b, mon_e.b.pc);
                check("b.id_pc", id_pc_b, mon_e.b.id_pc);
                check("b.id_instruction", 64'(id_instr_b), 64'(mon_e.b.instr));
                check("b.id_valid", 64'(valid_b), 64'(mon_e.b.valid));
                check("b.misalign_err", 64'(merr_b), 64'(mon_e.b.merr));
            end
        end
    end

    initial begin
        logic        r_rst, r_br, r_st;
        logic [63:0] r_tgt;
        int          sel;
        ma = '{64'h0, 64'h0, NOP, 1'b0, 1'b0};
        mb = ma;

        // Reset, including a reset that coincides with stall and a redirect.
        issue(1'b1, 1'b0, 64'h0, 1'b0);
        issue(1'b1, 1'b1, 64'h80, 1'b1);
        issue(1'b0, 1'b0, 64'h0, 1'b0);
        settle();
        check("first_fetch_pc", addr_a, 64'h4);
        check("first_fetch_id_pc", id_pc_a, 64'h0);
        check("first_fetch_valid", 64'(valid_a), 64'h1);
        check("wrap_addr", addr_b, 64'h0);
        check("wrap_id_pc", id_pc_b, RPC_B);
        issue(1'b0, 1'b0, 64'h0, 1'b0);
        settle();
        check("pc_at_8", addr_a, 64'h8);

        // Stall three cycles at PC=8, then release.
        repeat (3) issue(1'b0, 1'b0, 64'h0, 1'b1);
        settle();
        check("stall_pc", addr_a, 64'h8);
        check("stall_id_pc", id_pc_a, 64'h4);
        check("stall_id_instr", 64'(id_instr_a), 64'(mem_word(64'h4)));
        issue(1'b0, 1'b0, 64'h0, 1'b0);
        settle();
        check("release_pc", addr_a, 64'hC);

        // Redirect while stalled.
        issue(1'b0, 1'b1, 64'h40, 1'b1);
        settle();
        check("br_pc", addr_a, 64'h40);
        check("br_valid", 64'(valid_a), 64'h0);
        check("br_nop", 64'(id_instr_a), 64'(NOP));
        issue(1'b0, 1'b0, 64'h0, 1'b0);
        settle();
        check("after_br_id_pc", id_pc_a, 64'h40);
        check("after_br_valid", 64'(valid_a), 64'h1);

        // Misaligned redirect, self-redirect, back-to-back redirects.
        issue(1'b0, 1'b1, 64'h42, 1'b0);
        settle();
        check("misalign_pc", addr_a, CHK ? 64'h40 : 64'h42);
        check("misalign_flag", 64'(merr_a), 64'(CHK));
        issue(1'b0, 1'b1, ma.pc, 1'b0);
        issue(1'b0, 1'b1, 64'h100, 1'b0);
        issue(1'b0, 1'b1, 64'h200, 1'b1);
        settle();
        check("last_br_wins", addr_a, 64'h200);
        issue(1'b0, 1'b0, 64'h0, 1'b0);
        settle();
        check("misalign_sticky", 64'(merr_a), 64'(CHK));

        // Reset beating a same-cycle redirect.
        issue(1'b1, 1'b1, 64'h80, 1'b0);
        settle();
        check("rst_over_br_pc", addr_a, RPC_A);
        check("rst_over_br_valid", 64'(valid_a), 64'h0);
        check("rst_clears_flag", 64'(merr_a), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 99) < 3);
            r_br  = ($urandom_range(0, 99) < 15);
            r_st  = ($urandom_range(0, 99) < 25);
            sel   = $urandom_range(0, 3);
            case (sel)
                0:       r_tgt = {$urandom, $urandom};
                1:       r_tgt = {$urandom, $urandom} & ~64'h3;
                2:       r_tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: r_tgt = ma.pc;
            endcase
            issue(r_rst, r_br, r_tgt, r_st);
        end

        settle();
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
